// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and types for the arbitrated multiplexer and its picker.
package rr_arb_mux_pkg;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    // Width of a source index; never narrower than one bit so N=1 still has a port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Combinational rotating picker: first request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

    logic            found;
    logic [SELW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = SELW'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrated mux with burst locking and a one-entry registered output stage.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N         = 4,
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N-1:0]             in_valid,
    input  logic [N*WIDTH-1:0]       in_data,
    input  logic [N-1:0]             in_last,
    output logic [N-1:0]             in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic [sel_width(N)-1:0]  out_sel,
    input  logic                     out_ready
);

    localparam int unsigned SELW = sel_width(N);

    arb_state_e      state_q;
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] lock_q;
    logic            out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic            out_last_q;
    logic [SELW-1:0] out_sel_q;

    logic             can_load;
    logic [N-1:0]     lock_mask;
    logic [N-1:0]     req;
    logic [SELW-1:0]  pick_ptr;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  win_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [SELW-1:0]  ptr_next;

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        lock_mask         = '0;
        lock_mask[lock_q] = 1'b1;
    end

    // While locked only the burst owner may request; fixed priority always scans from 0.
    assign req      = (state_q == StLocked) ? (in_valid & lock_mask) : in_valid;
    assign pick_ptr = (PRIO_MODE == PRIO_FIXED) ? '0 : ptr_q;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign in_ready = can_load ? grant : '0;
    assign accept   = |in_ready;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    assign ptr_next = (win_idx == SELW'(N - 1)) ? '0 : win_idx + SELW'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            lock_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (can_load) begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= sel_data;
                out_last_q <= sel_last;
                out_sel_q  <= win_idx;
                if (sel_last) begin
                    state_q <= StIdle;
                    if (PRIO_MODE != PRIO_FIXED) begin
                        ptr_q <= ptr_next;
                    end
                end else begin
                    state_q <= StLocked;
                    lock_q  <= win_idx;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin and fixed-priority instances on shared stimulus.
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b1;

    logic [1:0][N-1:0] ir;
    logic [1:0]        ov;
    logic [1:0]        ol;
    logic [1:0][W-1:0] od;
    logic [1:0][1:0]   os;

    rr_arb_mux #(.WIDTH(W), .N(N), .PRIO_MODE(0)) u_rr (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_last(ol[0]), .out_sel(os[0]), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(N), .PRIO_MODE(1)) u_fix (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_last(ol[1]), .out_sel(os[1]), .out_ready(out_ready)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: index 0 = round-robin, 1 = fixed priority. lock = -1 means idle.
    int         m_ptr[2]  = '{0, 0};
    int         m_lock[2] = '{-1, -1};
    int         m_sel[2]  = '{0, 0};
    bit         m_v[2]    = '{0, 0};
    bit         m_last[2] = '{0, 0};
    logic [W-1:0] m_data[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int m);
        int base;
        if (m_lock[m] >= 0) return in_valid[m_lock[m]] ? m_lock[m] : -1;
        base = (m == 0) ? m_ptr[m] : 0;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic set_ch(input int i, input bit v, input bit last, input logic [W-1:0] d);
        in_valid[i]        = v;
        in_last[i]         = last;
        in_data[i*W +: W]  = d;
    endtask

    // One clock: check in_ready before the edge, advance model, check outputs after it.
    task automatic tick();
        int  g[2];
        bit  cl[2];
        string pfx;
        #1;
        for (int m = 0; m < 2; m++) begin
            pfx   = (m == 0) ? "rr" : "fix";
            cl[m] = !m_v[m] || out_ready;
            g[m]  = cl[m] ? pick(m) : -1;
            if (resetn)
                check({pfx, ".in_ready"}, 32'(ir[m]), (g[m] >= 0) ? (32'd1 << g[m]) : 32'd0);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            pfx = (m == 0) ? "rr" : "fix";
            if (!resetn) begin
                m_v[m] = 0; m_data[m] = '0; m_last[m] = 0; m_sel[m] = 0;
                m_ptr[m] = 0; m_lock[m] = -1;
            end else if (cl[m]) begin
                m_v[m] = (g[m] >= 0);
                if (g[m] >= 0) begin
                    m_data[m] = in_data[g[m]*W +: W];
                    m_last[m] = in_last[g[m]];
                    m_sel[m]  = g[m];
                    if (in_last[g[m]]) begin
                        m_lock[m] = -1;
                        if (m == 0) m_ptr[m] = (g[m] + 1) % N;
                    end else begin
                        m_lock[m] = g[m];
                    end
                end
            end
            check({pfx, ".out_valid"}, 32'(ov[m]), 32'(m_v[m]));
            if (m_v[m] || !resetn) begin
                check({pfx, ".out_data"}, od[m], m_data[m]);
                check({pfx, ".out_last"}, 32'(ol[m]), 32'(m_last[m]));
                check({pfx, ".out_sel"}, 32'(os[m]), 32'(m_sel[m]));
            end
        end
    endtask

    initial begin
        // Reset
        resetn = 1'b0;
        tick();
        tick();
        check("reset.out_valid", 32'(ov[0]), 32'd0);
        check("reset.out_sel", 32'(os[0]), 32'd0);
        resetn = 1'b1;

        // Round-robin fairness: all valid, single-beat packets
        for (int i = 0; i < N; i++) set_ch(i, 1, 1, 32'hA0 + 32'(i));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("fair.sel", 32'(os[0]), 32'(k % N));
            check("fair.data", od[0], 32'hA0 + 32'(k % N));
            check("fix.sel", 32'(os[1]), 32'd0);
        end

        // Move pointer to 1, then ch1 bursts three beats while ch0/ch2 stay valid
        in_valid = '0;
        set_ch(0, 1, 1, 32'hB0);
        tick();
        set_ch(2, 1, 1, 32'hB2);
        for (int b = 0; b < 5; b++) begin
            set_ch(1, 1, (b == 2), 32'hB10 + 32'(b));
            tick();
            if (b < 3) check("burst.sel", 32'(os[0]), 32'd1);
            else if (b == 3) check("burst.after", 32'(os[0]), 32'd2);
            else check("burst.wrap", 32'(os[0]), 32'd0);
        end

        // Backpressure: held beat stays stable, then drains with no bubble
        in_valid = '0;
        set_ch(0, 1, 1, 32'h12345678);
        tick();
        out_ready = 1'b0;
        set_ch(0, 1, 1, 32'h9);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp.data", od[0], 32'h12345678);
            check("bp.ready", 32'(ir[0]), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp.next_valid", 32'(ov[0]), 32'd1);
        check("bp.next_data", od[0], 32'h9);

        // Reset in the middle of a locked burst from ch2
        in_valid = '0;
        set_ch(2, 1, 0, 32'hC2);
        tick();
        out_ready = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        check("rst.valid", 32'(ov[0]), 32'd0);
        check("rst.data", od[0], 32'd0);
        check("rst.sel", 32'(os[0]), 32'd0);
        resetn = 1'b1;
        out_ready = 1'b1;
        set_ch(0, 1, 1, 32'hC0);
        set_ch(2, 1, 1, 32'hC2);
        tick();
        check("rst.first", 32'(os[0]), 32'd0);

        // Sparse: only ch3 with pointer at 0, then pointer wraps back to 0
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        in_valid = '0;
        set_ch(3, 1, 1, 32'hD3);
        tick();
        check("sparse.sel", 32'(os[0]), 32'd3);
        for (int i = 0; i < N; i++) set_ch(i, 1, 1, 32'hE0 + 32'(i));
        tick();
        check("sparse.wrap", 32'(os[0]), 32'd0);

        // Fixed priority: ch1 beats ch3 until it drops
        in_valid = '0;
        set_ch(1, 1, 1, 32'hF1);
        set_ch(3, 1, 1, 32'hF3);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fix.ch1", 32'(os[1]), 32'd1);
        end
        set_ch(1, 0, 1, 32'hF1);
        tick();
        check("fix.ch3", 32'(os[1]), 32'd3);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                in_last[i]        = ($urandom_range(0, 2) == 0);
                in_data[i*W +: W] = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            resetn    = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input, WIDTH-bit arbitrated multiplexer with valid/ready handshakes on every input and on the output.
- Selects one requesting source per cycle, by round-robin or fixed priority, and registers the result in a one-entry output stage.
- Supports multi-beat bursts: the grant stays locked to one source until its beat with last=1 is accepted.
- Sits between several datapath or bus request producers (e.g. instruction/data/uncached request queues) and a single downstream consumer such as the AXI bridge.

Parameters:
WIDTH, 32, data bits per channel
N, 4, number of input channels (2..16)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
SELW, derived localparam = max(1, clog2(N)), width of the source index

Ports:
clk  in  1  rising-edge clock
resetn  in  1  synchronous active-low reset
in_valid  in  N  per-channel request valid
in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_last  in  N  per-channel last-beat flag
in_ready  out  N  per-channel accept (one-hot or zero)
out_valid  out  1  output register holds a beat
out_data  out  WIDTH  registered selected data
out_last  out  1  registered last flag of that beat
out_sel  out  SELW  registered index of the source channel
out_ready  in  1  downstream accept

Behaviour:
- One clock (clk); reset is synchronous and active-low (resetn), sampled on the rising edge.
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer=0, state=IDLE, lock index=0.
- Reset asserted mid-burst: drops any held beat and any lock in the same edge. No partial state survives.
- Output stage:
  - can_load = !out_valid | out_ready.
  - A beat transfers downstream when out_valid & out_ready.
  - out_* are stable while out_valid & !out_ready.
- Grant is combinational from in_valid, state, pointer and can_load:
  - in_ready[i] = can_load & grant[i].
  - grant is one-hot or zero; in_ready may depend on in_valid.
  - At most one input is accepted per cycle.
- Latency: accept on edge k gives out_valid=1 with that data from edge k+1. Throughput is 1 beat/cycle when out_ready is held high.
- States:
  - IDLE: arbitrate among all in_valid.
    - PRIO_MODE=0: the winner is the first valid index at or after the pointer, wrapping N-1 -> 0.
    - PRIO_MODE=1: the lowest valid index wins and the pointer is unused.
    - On accept with in_last=0: go to LOCKED, lock index = winner.
    - On accept with in_last=1: stay in IDLE.
  - LOCKED: only the lock index may be granted; other channels see in_ready=0 even if valid.
    - On accept of a beat with in_last=1: go to IDLE.
    - A locked channel that deasserts valid stalls the arbiter. There is no timeout.
- Pointer update (PRIO_MODE=0):
  - On an accept with in_last=1: pointer = winner+1 mod N.
  - No update on non-last beats or on idle cycles.
- Boundary cases:
  - No valid inputs: grant=0, no state change.
  - All N valid: exactly one granted.
  - Pointer wraps from N-1 to 0.
  - Simultaneous drain and load in one cycle (out_valid & out_ready & new accept): the register is overwritten, out_valid stays 1, no bubble.
  - can_load=0: all in_ready=0 and arbitration state is frozen.
- N=1: degenerates to a one-stage registered pipe; out_sel is always 0.

Decomposition:
- Shared package holds:
  - PRIO_RR=0 and PRIO_FIXED=1 constants;
  - the IDLE/LOCKED state encoding;
  - a clog2-style SELW helper function.
- One natural sub-module, rr_pick:
  - purely combinational: N-bit request vector plus pointer -> one-hot grant and encoded index;
  - reusable for other arbiters.
- The top module holds the FSM, pointer, lock index and output register.

Test Plan:
- Reset mid-burst: lock channel 2, assert resetn=0 for 1 cycle with out_valid=1 -> next cycle out_valid=0, out_data=0, out_sel=0; then channel 0 (valid) is granted first.
- Round-robin fairness: N=4, all valid, in_last=1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_data matching each channel (e.g. 0xA0..0xA3).
- Burst lock: ch1 sends 3 beats (last on beat 3) while ch0 and ch2 stay valid -> out_sel=1,1,1, then 2 (pointer=2), then 3 if valid else 0; ch0/ch2 in_ready=0 throughout the burst.
- Backpressure: out_ready=0 for 5 cycles with data 0x12345678 held -> out_* stable, all in_ready=0; release -> one transfer, next beat follows with no bubble.
- Fixed priority: PRIO_MODE=1, ch3 and ch1 valid every cycle -> ch1 always granted; ch3 is granted only after ch1 drops valid.
- Sparse requests: only ch3 valid, pointer=0 -> ch3 granted via wrap-around; pointer then becomes 0.
